// File: rtl/ptmch_pkg.sv
// ptmch_pkg: opcode constants, TRG_PLS bit map and decoder FSM states shared with the counter block
package ptmch_pkg;
  localparam int NUM_TRG = 5;
  localparam logic [7:0] OPC_PRG_EXEC = 8'h10;
  localparam logic [7:0] OPC_RD_STAT  = 8'h0F;
  localparam logic [7:0] OPC_BLK_ERS  = 8'hD8;
  localparam logic [7:0] OPC_PG_RD    = 8'h13;
  localparam logic [7:0] OPC_WR_STAT  = 8'h1F;
  localparam int TRG_PRG_EXEC = 0;
  localparam int TRG_RD_STAT  = 1;
  localparam int TRG_BLK_ERS  = 2;
  localparam int TRG_PG_RD    = 3;
  localparam int TRG_WR_STAT  = 4;
  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} dec_state_t;
  function automatic logic [NUM_TRG-1:0] dec_opc(input logic [7:0] op);
    dec_opc = '0;
    dec_opc[TRG_PRG_EXEC] = op == OPC_PRG_EXEC;
    dec_opc[TRG_RD_STAT]  = op == OPC_RD_STAT;
    dec_opc[TRG_BLK_ERS]  = op == OPC_BLK_ERS;
    dec_opc[TRG_PG_RD]    = op == OPC_PG_RD;
    dec_opc[TRG_WR_STAT]  = op == OPC_WR_STAT;
  endfunction
endpackage

// File: rtl/ptmch_spi_dec_if.sv
// ptmch_spi_dec_if: snooped SPI bus (SCK, active-low CS_N, MOSI)
// master drives the bus, slave is the passive snooper
interface ptmch_spi_dec_if;
  logic SPI_SCK;
  logic SPI_CS_N;
  logic SPI_MOSI;
  modport master(output SPI_SCK, SPI_CS_N, SPI_MOSI);
  modport slave(input SPI_SCK, SPI_CS_N, SPI_MOSI);
endinterface

// File: rtl/ptmch_pls_stretch.sv
// ptmch_pls_stretch: stretches a one-cycle trigger into a PLS_WIDTH-cycle pulse
// ports: CLK100M, RESET_N (async low), trg (one-cycle request), pls (registered pulse)
module ptmch_pls_stretch #(
  parameter int PLS_WIDTH = 4
) (
  input  logic CLK100M,
  input  logic RESET_N,
  input  logic trg,
  output logic pls
);
  localparam logic [4:0] W = 5'(PLS_WIDTH);
  logic [4:0] cnt;
  // a new trigger restarts the count so a live pulse extends without a gap
  always_ff @(posedge CLK100M or negedge RESET_N)
    if (!RESET_N) begin
      cnt <= '0;
      pls <= 1'b0;
    end else if (trg) begin
      cnt <= 5'd1;
      pls <= 1'b1;
    end else if (pls) begin
      pls <= cnt != W;
      cnt <= cnt == W ? '0 : cnt + 5'd1;
    end
endmodule

// File: rtl/ptmch_spi_dec.sv
// ptmch_spi_dec: snoops SPI flash traffic, captures the opcode byte and pulses per-command triggers
// ports: CLK100M, RESET_N (async low), spi (snooped SCK/CS_N/MOSI),
//        TRG_PLS (per-command pulses), OPCODE (last opcode), OPC_VLD (capture strobe)
module ptmch_spi_dec
  import ptmch_pkg::*;
#(
  parameter int PLS_WIDTH   = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic               CLK100M,
  input  logic               RESET_N,
  ptmch_spi_dec_if.slave     spi,
  output logic [NUM_TRG-1:0] TRG_PLS,
  output logic [7:0]         OPCODE,
  output logic               OPC_VLD
);
  logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync, live;
  logic sck_d, cs_d, arm;
  logic sck_s, cs_s, mosi_s, sck_rise, cs_fall, bit_rise;
  logic clr, shift_en, capture;
  logic [2:0] bit_cnt;
  logic [7:0] sr, byte_d;
  logic [NUM_TRG-1:0] trg;
  dec_state_t state_q, state_d;
  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_d;
  assign bit_rise = sck_rise & ~cs_s;
  // arm only after a genuine CS_N high has come through the synchroniser, so
  // a reset released mid-transaction cannot fake a CS_N falling edge
  assign cs_fall  = arm & cs_d & ~cs_s;
  assign byte_d   = {sr[6:0], mosi_s};
  always_ff @(posedge CLK100M or negedge RESET_N)
    if (!RESET_N) begin
      sck_sync  <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      live      <= '0;
      sck_d     <= 1'b0;
      cs_d      <= 1'b1;
      arm       <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi.SPI_SCK};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi.SPI_CS_N};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi.SPI_MOSI};
      live      <= {live[SYNC_STAGES-2:0], 1'b1};
      sck_d     <= sck_s;
      cs_d      <= cs_s;
      arm       <= arm | (live[SYNC_STAGES-1] & cs_s);
    end
  always_ff @(posedge CLK100M or negedge RESET_N)
    if (!RESET_N) state_q <= IDLE;
    else state_q <= state_d;
  always_comb
    state_d = state_q == IDLE ? (cs_fall ? SHIFT : IDLE)
            : cs_s ? IDLE
            : state_q == SHIFT && bit_rise && bit_cnt == 3'd7 ? HOLD
            : state_q;
  always_comb begin
    clr      = state_q == IDLE && cs_fall;
    shift_en = state_q == SHIFT && bit_rise;
    capture  = shift_en && bit_cnt == 3'd7;
  end
  always_ff @(posedge CLK100M or negedge RESET_N)
    if (!RESET_N) begin
      bit_cnt <= '0;
      sr      <= '0;
      OPCODE  <= '0;
      OPC_VLD <= 1'b0;
    end else begin
      bit_cnt <= clr ? 3'd0 : shift_en ? bit_cnt + 3'd1 : bit_cnt;
      sr      <= clr ? 8'd0 : shift_en ? byte_d : sr;
      OPCODE  <= capture ? byte_d : OPCODE;
      OPC_VLD <= capture;
    end
  assign trg = capture ? dec_opc(byte_d) : '0;
  for (genvar i = 0; i < NUM_TRG; i++) begin : g_pls
    ptmch_pls_stretch #(.PLS_WIDTH(PLS_WIDTH)) u_pls (
      .CLK100M(CLK100M),
      .RESET_N(RESET_N),
      .trg(trg[i]),
      .pls(TRG_PLS[i])
    );
  end
endmodule

// File: tb/tb_ptmch_spi_dec.sv
// tb_ptmch_spi_dec: directed bench with opcode scoreboard and pulse-width monitors
`timescale 1ns/1ps
module tb_ptmch_spi_dec;
  typedef struct {logic [7:0] op; logic [4:0] mask;} exp_t;
  logic CLK100M = 1'b0;
  logic RESET_N = 1'b0;
  logic [4:0] trg, trg16, trg_p, trg16_p;
  logic [7:0] opc, opc16;
  logic vld, vld16;
  exp_t q[$];
  exp_t e_cur;
  int n_assert = 0, n_fail = 0;
  int vld_cnt = 0, rises16 = 0;
  int rises[5], exp_rises[5], w[5], w16[5];
  ptmch_spi_dec_if spi();
  ptmch_spi_dec u_dut (
    .CLK100M(CLK100M), .RESET_N(RESET_N), .spi(spi.slave),
    .TRG_PLS(trg), .OPCODE(opc), .OPC_VLD(vld)
  );
  ptmch_spi_dec #(.PLS_WIDTH(16)) u_dut16 (
    .CLK100M(CLK100M), .RESET_N(RESET_N), .spi(spi.slave),
    .TRG_PLS(trg16), .OPCODE(opc16), .OPC_VLD(vld16)
  );
  always #5 CLK100M = ~CLK100M;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [4:0] model(input logic [7:0] op);
    case (op)
      8'h10:   return 5'b00001;
      8'h0F:   return 5'b00010;
      8'hD8:   return 5'b00100;
      8'h13:   return 5'b01000;
      8'h1F:   return 5'b10000;
      default: return 5'b00000;
    endcase
  endfunction
  task automatic spi_bits(input logic [7:0] v, input int n, input int hp);
    for (int i = 0; i < n; i++) begin
      spi.SPI_MOSI = v[7-i];
      #hp;
      spi.SPI_SCK = 1'b1;
      #hp;
      spi.SPI_SCK = 1'b0;
    end
  endtask
  task automatic xact(input logic [7:0] op, input int naddr, input int hp, input int gap);
    exp_t e;
    e.op = op;
    e.mask = model(op);
    q.push_back(e);
    for (int b = 0; b < 5; b++) if (e.mask[b]) exp_rises[b]++;
    spi.SPI_CS_N = 1'b0;
    #hp;
    spi_bits(op, 8, hp);
    for (int a = 0; a < naddr; a++) spi_bits(8'($urandom), 8, hp);
    #hp;
    spi.SPI_CS_N = 1'b1;
    #gap;
  endtask
  always @(negedge CLK100M) begin
    if (!RESET_N) begin
      for (int b = 0; b < 5; b++) begin
        w[b] = 0;
        w16[b] = 0;
      end
      trg_p = '0;
      trg16_p = '0;
    end else begin
      if (vld) begin
        vld_cnt++;
        chk("vld_expected", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) begin
          e_cur = q.pop_front();
          chk("opcode", 32'(opc), 32'(e_cur.op));
          chk("trg_at_vld", 32'(trg), 32'(e_cur.mask));
        end
      end
      for (int b = 0; b < 5; b++) begin
        if (trg[b]) begin
          w[b]++;
          if (!trg_p[b]) rises[b]++;
        end else if (w[b] != 0) begin
          chk("width4", w[b], 4);
          w[b] = 0;
        end
        if (trg16[b]) begin
          w16[b]++;
          if (!trg16_p[b] && b == 0) rises16++;
        end else if (w16[b] != 0) begin
          chk("width16", w16[b], 16);
          w16[b] = 0;
        end
      end
      trg_p = trg;
      trg16_p = trg16;
    end
  end
  initial begin
    logic [7:0] ops [4];
    ops = '{8'h0F, 8'hD8, 8'h13, 8'h1F};
    for (int b = 0; b < 5; b++) begin
      rises[b] = 0;
      exp_rises[b] = 0;
    end
    spi.SPI_SCK = 1'b0;
    spi.SPI_CS_N = 1'b1;
    spi.SPI_MOSI = 1'b0;
    #23;
    chk("rst_trg", 32'(trg), 32'd0);
    chk("rst_opc", 32'(opc), 32'd0);
    chk("rst_vld", 32'(vld), 32'd0);
    chk("rst_trg16", 32'(trg16), 32'd0);
    chk("rst_opc16", 32'(opc16), 32'd0);
    chk("rst_vld16", 32'(vld16), 32'd0);
    RESET_N = 1'b1;
    #103;
    xact(8'h10, 0, 50, 200);
    chk("opc_10", 32'(opc), 32'h10);
    chk("vld_cnt_10", vld_cnt, 1);
    foreach (ops[k]) xact(ops[k], 3, 50, 200);
    chk("vld_cnt_addr", vld_cnt, 5);
    xact(8'h9F, 0, 50, 200);
    chk("opc_9f", 32'(opc), 32'h9F);
    chk("vld_cnt_9f", vld_cnt, 6);
    spi.SPI_CS_N = 1'b0;
    #50;
    spi_bits(8'h10, 5, 50);
    #50;
    spi.SPI_CS_N = 1'b1;
    #200;
    chk("opc_abort", 32'(opc), 32'h9F);
    chk("vld_cnt_abort", vld_cnt, 6);
    chk("trg_abort", 32'(trg), 32'd0);
    xact(8'h13, 0, 50, 200);
    chk("opc_13", 32'(opc), 32'h13);
    spi.SPI_CS_N = 1'b0;
    #50;
    spi_bits(8'hD8, 4, 50);
    @(posedge CLK100M);
    #1 RESET_N = 1'b0;
    #1 chk("opc_in_rst", 32'(opc), 32'd0);
    repeat (3) @(posedge CLK100M);
    #1 RESET_N = 1'b1;
    spi_bits(8'h80, 4, 50);
    spi_bits(8'h10, 8, 50);
    #50;
    spi.SPI_CS_N = 1'b1;
    #200;
    chk("opc_after_rst", 32'(opc), 32'd0);
    chk("vld_cnt_rst", vld_cnt, 7);
    chk("trg_after_rst", 32'(trg), 32'd0);
    xact(8'hD8, 0, 50, 200);
    chk("opc_d8", 32'(opc), 32'hD8);
    chk("vld_cnt_d8", vld_cnt, 8);
    rises16 = 0;
    xact(8'h10, 0, 20, 40);
    xact(8'h10, 0, 20, 40);
    #400;
    chk("rises16", rises16, 2);
    chk("vld_cnt_end", vld_cnt, 10);
    chk("q_empty", q.size(), 0);
    for (int b = 0; b < 5; b++) chk($sformatf("rises_bit%0d", b), rises[b], exp_rises[b]);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
